// File: rtl/sysbus_xfer.sv
// sysbus_xfer: MERA-400 system bus transfer stage.
// Arbitrates, drives one bus transaction and returns the answer to the CPU.
module sysbus_xfer #(
   parameter int SETUP_TICKS = 2,
   parameter int ALARM_TICKS = 200,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_sys,
   input  logic        clo_n,
   input  logic        zg,
   input  logic        dr,
   input  logic        dw,
   input  logic        df,
   input  logic        ds,
   input  logic        din,
   input  logic        dmcl,
   input  logic [0:15] dad,
   input  logic [0:15] ddt,
   input  logic [0:3]  nb,
   output logic        zw,
   output logic        rok,
   output logic        ren,
   output logic        rpe,
   output logic        talarm,
   output logic [0:15] rdt,
   output logic        bus_rq,
   input  logic        bus_gnt,
   output logic        bus_r,
   output logic        bus_w,
   output logic        bus_f,
   output logic        bus_s,
   output logic        bus_in,
   output logic        bus_cl,
   output logic [0:15] bus_ad,
   output logic [0:15] bus_dt,
   output logic [0:3]  bus_nb,
   input  logic        bus_ok,
   input  logic        bus_en,
   input  logic        bus_pe,
   input  logic [0:15] bus_dt_in
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_SETUP,
      S_WAIT,
      S_HOLD
   } state_t;

   localparam logic [11:0] SETUP_LAST = 12'(SETUP_TICKS - 1);
   localparam logic [11:0] ALARM_LAST = 12'(ALARM_TICKS - 1);

   // answer bits and read data share one synchroniser word: {ok,en,pe,dt}
   logic [SYNC_STAGES-1:0][18:0] sync_q, sync_d;
   logic [18:0] sync_last;
   logic        s_ok, s_en, s_pe, s_any;
   logic [0:15] s_dt;

   state_t      state_q, state_d;
   logic [11:0] cnt_q, cnt_d;
   logic        rdcmd_q, rdcmd_d;
   logic        mcl_q, mcl_d;
   logic [5:0]  bcmd_q, bcmd_d;
   logic [0:15] ad_q, ad_d;
   logic [0:15] dt_q, dt_d;
   logic [0:3]  nb_q, nb_d;
   logic        zw_q, zw_d;
   logic        rq_q, rq_d;
   logic        rok_q, rok_d;
   logic        ren_q, ren_d;
   logic        rpe_q, rpe_d;
   logic        alarm_q, alarm_d;
   logic [0:15] rdt_q, rdt_d;
   logic [5:0]  cmd_in;

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign s_ok      = sync_last[18];
   assign s_en      = sync_last[17];
   assign s_pe      = sync_last[16];
   assign s_dt      = sync_last[15:0];
   assign s_any     = s_ok | s_en | s_pe;
   assign cmd_in    = {dr, dw, df, ds, din, dmcl};

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0],
                {bus_ok, bus_en, bus_pe, bus_dt_in}};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdcmd_d = rdcmd_q;
      mcl_d   = mcl_q;
      bcmd_d  = bcmd_q;
      ad_d    = ad_q;
      dt_d    = dt_q;
      nb_d    = nb_q;
      zw_d    = zw_q;
      rq_d    = rq_q;
      rok_d   = rok_q;
      ren_d   = ren_q;
      rpe_d   = rpe_q;
      alarm_d = alarm_q;
      rdt_d   = rdt_q;
      case (state_q)
         S_IDLE: begin
            if (zg) begin
               state_d = S_ARB;
               rq_d    = 1'b1;
            end
         end
         S_ARB: begin
            if (bus_gnt) begin
               state_d = S_SETUP;
               zw_d    = 1'b1;
               cnt_d   = '0;
            end else if (!zg) begin
               state_d = S_IDLE;
               rq_d    = 1'b0;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               rdcmd_d = dr | df;
               mcl_d   = dmcl;
               ad_d    = dad;
               dt_d    = ddt;
               nb_d    = nb;
               cnt_d   = '0;
               bcmd_d  = cmd_in;
               state_d = (cmd_in == 6'd0) ? S_HOLD : S_WAIT;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         S_WAIT: begin
            if (mcl_q) begin
               rok_d   = 1'b1;
               bcmd_d  = '0;
               state_d = S_HOLD;
            end else if (s_any) begin
               rok_d   = s_ok;
               ren_d   = s_en;
               rpe_d   = s_pe;
               bcmd_d  = '0;
               state_d = S_HOLD;
               if (rdcmd_q) rdt_d = s_dt;
            end else if (cnt_q == ALARM_LAST) begin
               alarm_d = 1'b1;
               bcmd_d  = '0;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         S_HOLD: begin
            if (!zg && !s_any) begin
               state_d = S_IDLE;
               zw_d    = 1'b0;
               rq_d    = 1'b0;
               rok_d   = 1'b0;
               ren_d   = 1'b0;
               rpe_d   = 1'b0;
               alarm_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge clo_n) begin
      if (!clo_n) begin
         sync_q  <= '0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdcmd_q <= 1'b0;
         mcl_q   <= 1'b0;
         bcmd_q  <= '0;
         ad_q    <= '0;
         dt_q    <= '0;
         nb_q    <= '0;
         zw_q    <= 1'b0;
         rq_q    <= 1'b0;
         rok_q   <= 1'b0;
         ren_q   <= 1'b0;
         rpe_q   <= 1'b0;
         alarm_q <= 1'b0;
         rdt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdcmd_q <= rdcmd_d;
         mcl_q   <= mcl_d;
         bcmd_q  <= bcmd_d;
         ad_q    <= ad_d;
         dt_q    <= dt_d;
         nb_q    <= nb_d;
         zw_q    <= zw_d;
         rq_q    <= rq_d;
         rok_q   <= rok_d;
         ren_q   <= ren_d;
         rpe_q   <= rpe_d;
         alarm_q <= alarm_d;
         rdt_q   <= rdt_d;
      end
   end

   assign zw     = zw_q;
   assign bus_rq = rq_q;
   assign rok    = rok_q;
   assign ren    = ren_q;
   assign rpe    = rpe_q;
   assign talarm = alarm_q;
   assign rdt    = rdt_q;
   assign bus_ad = ad_q;
   assign bus_dt = dt_q;
   assign bus_nb = nb_q;
   assign {bus_r, bus_w, bus_f, bus_s, bus_in, bus_cl} = bcmd_q;

endmodule

// File: tb/tb_sysbus_xfer.sv
// tb_sysbus_xfer: directed bench for sysbus_xfer.
// Expected answers are queued at stimulus time and popped on each CPU answer.
module tb_sysbus_xfer;

   logic        clk_sys = 1'b0;
   logic        clo_n = 1'b1;
   logic        zg = 1'b0;
   logic        dr = 1'b0, dw = 1'b0, df = 1'b0;
   logic        ds = 1'b0, din = 1'b0, dmcl = 1'b0;
   logic [0:15] dad = '0, ddt = '0;
   logic [0:3]  nb = '0;
   logic        bus_gnt = 1'b0;
   logic        bus_ok = 1'b0, bus_en = 1'b0, bus_pe = 1'b0;
   logic [0:15] bus_dt_in = '0;
   logic        zw, rok, ren, rpe, talarm, bus_rq;
   logic [0:15] rdt, bus_ad, bus_dt;
   logic [0:3]  bus_nb;
   logic        bus_r, bus_w, bus_f, bus_s, bus_in, bus_cl;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic        rok;
      logic        ren;
      logic        rpe;
      logic        alarm;
      logic [0:15] rdt;
   } exp_t;

   exp_t sb[$];

   localparam int SEL_ZW = 0;
   localparam int SEL_R  = 1;
   localparam int SEL_W  = 2;
   localparam int SEL_CL = 3;
   localparam int SEL_RQ = 4;

   sysbus_xfer #(
      .SETUP_TICKS(2),
      .ALARM_TICKS(16),
      .SYNC_STAGES(2)
   ) dut (
      .clk_sys(clk_sys), .clo_n(clo_n), .zg(zg),
      .dr(dr), .dw(dw), .df(df), .ds(ds), .din(din), .dmcl(dmcl),
      .dad(dad), .ddt(ddt), .nb(nb),
      .zw(zw), .rok(rok), .ren(ren), .rpe(rpe), .talarm(talarm),
      .rdt(rdt), .bus_rq(bus_rq), .bus_gnt(bus_gnt),
      .bus_r(bus_r), .bus_w(bus_w), .bus_f(bus_f), .bus_s(bus_s),
      .bus_in(bus_in), .bus_cl(bus_cl),
      .bus_ad(bus_ad), .bus_dt(bus_dt), .bus_nb(bus_nb),
      .bus_ok(bus_ok), .bus_en(bus_en), .bus_pe(bus_pe),
      .bus_dt_in(bus_dt_in)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   function automatic logic pick(input int sel);
      case (sel)
         SEL_ZW:  return zw;
         SEL_R:   return bus_r;
         SEL_W:   return bus_w;
         SEL_CL:  return bus_cl;
         SEL_RQ:  return bus_rq;
         default: return 1'bx;
      endcase
   endfunction

   task automatic wait_until(input string tag, input int sel,
                             input logic val, input int budget);
      int  n;
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         cyc(1);
         n++;
         hit = (pick(sel) === val);
      end
      chk(tag, {31'd0, hit}, 32'd1);
   endtask

   task automatic push(input logic k, input logic e, input logic p,
                       input logic a, input logic [0:15] d);
      exp_t x;
      x.rok = k;
      x.ren = e;
      x.rpe = p;
      x.alarm = a;
      x.rdt = d;
      sb.push_back(x);
   endtask

   task automatic get_resp(input string tag, input int budget);
      exp_t e;
      int   n;
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         cyc(1);
         n++;
         hit = rok | ren | rpe | talarm;
      end
      chk({tag, "_seen"}, {31'd0, hit}, 32'd1);
      chk({tag, "_sbq"}, {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_rok"}, {31'd0, rok}, {31'd0, e.rok});
         chk({tag, "_ren"}, {31'd0, ren}, {31'd0, e.ren});
         chk({tag, "_rpe"}, {31'd0, rpe}, {31'd0, e.rpe});
         chk({tag, "_alarm"}, {31'd0, talarm}, {31'd0, e.alarm});
         chk({tag, "_rdt"}, {16'd0, rdt}, {16'd0, e.rdt});
      end
   endtask

   initial begin
      #1 clo_n = 1'b0;
      cyc(2);
      chk("rst_ctl", {20'd0, zw, rok, ren, rpe, talarm, bus_rq,
                      bus_r, bus_w, bus_f, bus_s, bus_in, bus_cl}, 32'd0);
      chk("rst_rdt", {16'd0, rdt}, 32'd0);
      chk("rst_ad", {bus_ad, bus_dt}, 32'd0);
      clo_n = 1'b1;
      cyc(1);

      // read, address changed during the first SETUP cycle
      zg = 1'b1;
      bus_gnt = 1'b1;
      dr = 1'b1;
      dad = 16'hFFFF;
      nb = 4'h5;
      push(1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF);
      cyc(2);
      chk("rd_zw", {31'd0, zw}, 32'd1);
      chk("rd_setup0", {31'd0, bus_r}, 32'd0);
      dad = 16'h1234;
      cyc(1);
      chk("rd_setup1", {31'd0, bus_r}, 32'd0);
      cyc(1);
      chk("rd_bus_r", {31'd0, bus_r}, 32'd1);
      chk("rd_bus_ad", {16'd0, bus_ad}, 32'h1234);
      chk("rd_bus_nb", {28'd0, bus_nb}, 32'h5);
      cyc(4);
      chk("rd_wait_r", {31'd0, bus_r}, 32'd1);
      bus_ok = 1'b1;
      bus_dt_in = 16'hBEEF;
      cyc(2);
      chk("rd_lat", {31'd0, rok}, 32'd0);
      get_resp("rd", 1);
      chk("rd_hold_r", {31'd0, bus_r}, 32'd0);
      chk("rd_hold_ad", {16'd0, bus_ad}, 32'h1234);
      zg = 1'b0;
      dr = 1'b0;
      bus_ok = 1'b0;
      wait_until("rd_rel", SEL_ZW, 1'b0, 4);
      chk("rd_rel_rok", {30'd0, rok, bus_rq}, 32'd0);
      chk("rd_rel_rdt", {16'd0, rdt}, 32'hBEEF);

      // write with simultaneous EN and PE
      zg = 1'b1;
      dw = 1'b1;
      ddt = 16'h00FF;
      dad = 16'h0042;
      push(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
      wait_until("wr_bus_w", SEL_W, 1'b1, 8);
      chk("wr_bus_dt", {16'd0, bus_dt}, 32'h00FF);
      chk("wr_bus_r", {31'd0, bus_r}, 32'd0);
      bus_en = 1'b1;
      bus_pe = 1'b1;
      bus_dt_in = 16'h1111;
      get_resp("wr", 5);
      zg = 1'b0;
      dw = 1'b0;
      bus_en = 1'b0;
      bus_pe = 1'b0;
      wait_until("wr_rel", SEL_ZW, 1'b0, 4);

      // timeout, no answer
      zg = 1'b1;
      dr = 1'b1;
      bus_dt_in = 16'h0000;
      push(1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
      wait_until("tmo_bus_r", SEL_R, 1'b1, 8);
      cyc(15);
      chk("tmo_early", {30'd0, talarm, bus_r}, 32'd1);
      get_resp("tmo", 1);
      chk("tmo_r_drop", {31'd0, bus_r}, 32'd0);
      chk("tmo_zw", {31'd0, zw}, 32'd1);
      zg = 1'b0;
      dr = 1'b0;
      wait_until("tmo_rel", SEL_ZW, 1'b0, 4);

      // answer seen in the last counter cycle beats the alarm
      zg = 1'b1;
      dr = 1'b1;
      push(1'b1, 1'b0, 1'b0, 1'b0, 16'hCAFE);
      wait_until("tma_bus_r", SEL_R, 1'b1, 8);
      cyc(13);
      bus_ok = 1'b1;
      bus_dt_in = 16'hCAFE;
      cyc(2);
      chk("tma_early", {30'd0, rok, talarm}, 32'd0);
      get_resp("tma", 1);
      zg = 1'b0;
      dr = 1'b0;
      bus_ok = 1'b0;
      wait_until("tma_rel", SEL_ZW, 1'b0, 4);

      // arbitration abort
      bus_gnt = 1'b0;
      zg = 1'b1;
      dr = 1'b1;
      cyc(2);
      chk("arb_rq", {31'd0, bus_rq}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("arb_nozw", {30'd0, zw, bus_r}, 32'd0);
      end
      zg = 1'b0;
      dr = 1'b0;
      cyc(1);
      chk("arb_rq_drop", {31'd0, bus_rq}, 32'd0);
      cyc(2);
      chk("arb_idle", {30'd0, zw, bus_rq}, 32'd0);

      // MCL
      bus_gnt = 1'b1;
      zg = 1'b1;
      dmcl = 1'b1;
      push(1'b1, 1'b0, 1'b0, 1'b0, 16'hCAFE);
      wait_until("mcl_cl", SEL_CL, 1'b1, 8);
      chk("mcl_rok0", {31'd0, rok}, 32'd0);
      get_resp("mcl", 1);
      chk("mcl_cl_drop", {31'd0, bus_cl}, 32'd0);
      zg = 1'b0;
      dmcl = 1'b0;
      wait_until("mcl_rel", SEL_ZW, 1'b0, 4);

      // reset in the middle of WAIT
      zg = 1'b1;
      dr = 1'b1;
      dad = 16'h0F0F;
      wait_until("rst_bus_r", SEL_R, 1'b1, 8);
      #2 clo_n = 1'b0;
      #1;
      chk("arst_ctl", {20'd0, zw, rok, ren, rpe, talarm, bus_rq,
                       bus_r, bus_w, bus_f, bus_s, bus_in, bus_cl}, 32'd0);
      chk("arst_rdt", {16'd0, rdt}, 32'd0);
      chk("arst_bus", {bus_ad, bus_dt}, 32'd0);
      bus_gnt = 1'b0;
      cyc(2);
      clo_n = 1'b1;
      cyc(1);
      chk("post_arb", {29'd0, bus_rq, zw, bus_r}, 32'd4);
      bus_gnt = 1'b1;
      push(1'b1, 1'b0, 1'b0, 1'b0, 16'h5A5A);
      wait_until("post_bus_r", SEL_R, 1'b1, 8);
      chk("post_ad", {16'd0, bus_ad}, 32'h0F0F);
      bus_ok = 1'b1;
      bus_dt_in = 16'h5A5A;
      get_resp("post", 5);
      zg = 1'b0;
      dr = 1'b0;
      bus_ok = 1'b0;
      wait_until("post_rel", SEL_ZW, 1'b0, 4);
      chk("sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
